machine_ctrl: RTL and testbench
===============================

// Module: machine_ctrl
// PURPOSE
//  8-step instruction sequencer for the 8-bit accumulator CPU; sits directly downstream of the instruction register.
//  Drives load_ir/rd/inc_pc in the two fetch steps that fill the 16-bit IR, then decodes opcode = IR[15:13].
//  Issues one instruction's control strobes per 8-cycle frame to the PC, ALU/accumulator, data-bus gate and RAM/ROM.
// PARAMETERS
//  OPC_W       3   opcode width (IR[15:13]); fixed encoding below
//  HALT_STICKY 1   1: HLT parks the sequencer until reset; 0: HLT strobes halt for one cycle then continues
// PORTS
//  clk1        in   1      single system clock, all state on posedge
//  rst         in   1      asynchronous, active-low reset
//  ena         in   1      run enable from the reset/start block; low = sequencer held at S0
//  opcode      in   OPC_W  IR[15:13]; must be stable from S2 through S7
//  zero        in   1      accumulator == 0 flag, sampled combinationally in S6/S7
//  step        in   1      single-step request (port exists only with MACHINE_STEP_EN)
//  load_ir     out  1      IR byte-load enable
//  rd          out  1      memory read strobe
//  wr          out  1      memory write strobe
//  inc_pc      out  1      PC increment
//  load_pc     out  1      PC load from IR[12:0]
//  load_acc    out  1      accumulator load from ALU
//  datactl_ena out  1      drive accumulator onto data bus
//  halt        out  1      CPU halted indication
//  state       out  3      current step S0..S7 (debug/bench visibility)
// BEHAVIOUR
//  Opcodes: HLT=000 SKZ=001 ADD=010 AND=011 XOR=100 LDA=101 STO=110 JMP=111; ALUOP = ADD|AND|XOR|LDA.
//  state: 3-bit counter S0->S1->...->S7->S0, advances one step per clk1 while ena=1 and not halted.
//  Outputs: combinational decode of state/opcode/zero only; each output is valid in the same cycle as its step.
//  Strobes not listed for a step are 0.
//  Step table:
//   S0: load_ir=1 rd=1 inc_pc=1 (IR high byte)      S1: load_ir=1 rd=1 inc_pc=1 (IR low byte)
//   S2: all 0 (opcode settles)                       S3: HLT -> halt=1; else inc_pc=1
//   S4: ALUOP -> rd=1; STO -> datactl_ena=1; JMP -> load_pc=1
//   S5: ALUOP -> rd=1 load_acc=1; STO -> datactl_ena=1 wr=1; JMP -> load_pc=1
//   S6: STO -> datactl_ena=1; SKZ & zero -> inc_pc=1
//   S7: SKZ & zero -> inc_pc=1
//  Cycle count: every instruction takes exactly 8 cycles.
//  SKZ with zero=1 advances PC by 2, skipping one 16-bit instruction.
//  Halt, HALT_STICKY=1:
//   - at the S3 edge with opcode=HLT, enter HALTED; state stays 3'd3, halt=1, all other strobes 0.
//   - exits only on rst; ena low does not clear HALTED.
//  Halt, HALT_STICKY=0: halt=1 for the S3 cycle only; the sequence continues to S4.
//  ena low:
//   - next edge forces state=S0 with all strobes 0, even mid-instruction (the aborted instruction is not completed).
//   - sequence restarts at S0 on the first edge with ena=1.
//  Reset (asynchronous, active-low):
//   - state=S0, HALTED cleared; all outputs 0 while rst=0, including load_ir/rd/inc_pc.
//   - mid-instruction reset aborts immediately; no strobe may glitch high during reset.
//  rst deassertion with ena=1: S0 fetch strobes appear in the first cycle.
// CONFIGURATION
//  MACHINE_STEP_EN defined:
//   - step input exists; sequencer waits in S0 with all strobes 0 until step=1.
//   - one step pulse runs exactly one full instruction (S0..S7) then waits at S0 again.
//   - step held high = free-run.
//  MACHINE_STEP_EN undefined: no step port; free-running whenever ena=1.
// STRUCTURE
//  Shared package cpu_pkg:
//   - opcode localparams (OPC_HLT..OPC_JMP), step localparams S0..S7, ALUOP decode function.
//  One sub-module machine_decode: pure combinational state/opcode/zero -> strobe table.
//  Top: state counter, HALTED flag, step gate.
// TESTING
//  1. Reset: rst=0 mid-S5 of ADD -> all outputs 0 immediately; release with ena=1 -> S0 load_ir=rd=inc_pc=1.
//  2. ADD (010): 8 cycles -> inc_pc high in S0,S1,S3 (3 pulses); rd in S0,S1,S4,S5; load_acc only in S5.
//  3. STO (110): datactl_ena in S4..S6, wr only in S5, rd never after S1.
//  4. SKZ (001): zero=1 -> inc_pc pulses in S6,S7 (5 total); zero=0 -> 3 total.
//  5. JMP (111): load_pc=1 in S4,S5 and no inc_pc after S3; HLT (000), HALT_STICKY=1 -> halt=1, state=3 held 20 cycles, ena toggle ignored.
//  6. ena drops in S4 of LDA -> next cycle state=0, strobes 0; MACHINE_STEP_EN: one step pulse -> exactly 8 cycles, then idle at S0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode/step encodings and control-strobe bundle for the
// accumulator CPU sequencer.
package cpu_pkg;

    localparam int OPC_W = 3;

    localparam logic [OPC_W-1:0] OPC_HLT = 3'b000;
    localparam logic [OPC_W-1:0] OPC_SKZ = 3'b001;
    localparam logic [OPC_W-1:0] OPC_ADD = 3'b010;
    localparam logic [OPC_W-1:0] OPC_AND = 3'b011;
    localparam logic [OPC_W-1:0] OPC_XOR = 3'b100;
    localparam logic [OPC_W-1:0] OPC_LDA = 3'b101;
    localparam logic [OPC_W-1:0] OPC_STO = 3'b110;
    localparam logic [OPC_W-1:0] OPC_JMP = 3'b111;

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;
    localparam logic [2:0] S6 = 3'd6;
    localparam logic [2:0] S7 = 3'd7;

    typedef struct packed {
        logic load_ir;
        logic rd;
        logic wr;
        logic inc_pc;
        logic load_pc;
        logic load_acc;
        logic datactl_ena;
        logic halt;
    } strobes_t;

    // Opcodes that read an operand and run it through the ALU into the accumulator
    function automatic logic is_aluop(input logic [OPC_W-1:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_AND) ||
               (opc == OPC_XOR) || (opc == OPC_LDA);
    endfunction

endpackage

// File: rtl/machine_decode.sv
// machine_decode: pure combinational step/opcode/zero -> control strobe table.
module machine_decode
    import cpu_pkg::*;
(
    input  logic [2:0]       state,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    output strobes_t         strb
);

    // one row of the strobe table per sequencer step
    always_comb begin
        strb = '0;
        case (state)
            S0, S1: begin
                strb.load_ir = 1'b1;
                strb.rd      = 1'b1;
                strb.inc_pc  = 1'b1;
            end
            S2: begin
            end
            S3: begin
                if (opcode == OPC_HLT) strb.halt   = 1'b1;
                else                   strb.inc_pc = 1'b1;
            end
            S4: begin
                strb.rd          = is_aluop(opcode);
                strb.datactl_ena = (opcode == OPC_STO);
                strb.load_pc     = (opcode == OPC_JMP);
            end
            S5: begin
                strb.rd          = is_aluop(opcode);
                strb.load_acc    = is_aluop(opcode);
                strb.datactl_ena = (opcode == OPC_STO);
                strb.wr          = (opcode == OPC_STO);
                strb.load_pc     = (opcode == OPC_JMP);
            end
            S6: begin
                strb.datactl_ena = (opcode == OPC_STO);
                strb.inc_pc      = (opcode == OPC_SKZ) && zero;
            end
            S7: begin
                strb.inc_pc      = (opcode == OPC_SKZ) && zero;
            end
        endcase
    end

endmodule

// File: rtl/machine_ctrl.sv
// machine_ctrl: 8-step instruction sequencer for the 8-bit accumulator CPU.
// Optional single-step gate: define MACHINE_STEP_EN to add the step input.
//
// state | meaning
// S0    | fetch IR high byte; waits here while ena low (or for step)
// S1    | fetch IR low byte
// S2    | opcode settles
// S3    | HLT check, otherwise PC increment; parks here when halted
// S4    | operand read / store drive / jump load
// S5    | accumulate / memory write / jump load
// S6    | store drive tail, SKZ skip increment
// S7    | SKZ skip increment
module machine_ctrl
    import cpu_pkg::*;
#(
    parameter int HALT_STICKY = 1
)(
    input  logic             clk1,
    input  logic             rst,
    input  logic             ena,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
`ifdef MACHINE_STEP_EN
    input  logic             step,
`endif
    output logic             load_ir,
    output logic             rd,
    output logic             wr,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_acc,
    output logic             datactl_ena,
    output logic             halt,
    output logic [2:0]       state
);

    logic     halted;
    logic     start;
    logic     active;
    strobes_t dec;

`ifdef MACHINE_STEP_EN
    assign start = step;
`else
    assign start = 1'b1;
`endif

    machine_decode u_decode (
        .state  (state),
        .opcode (opcode),
        .zero   (zero),
        .strb   (dec)
    );

    // step counter with ena abort, S0 run gate and sticky halt park
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state  <= S0;
            halted <= 1'b0;
        end else if (!halted) begin
            if (!ena) begin
                state <= S0;
            end else if (state == S0 && !start) begin
                state <= S0;
            end else if (state == S3 && opcode == OPC_HLT && HALT_STICKY != 0) begin
                halted <= 1'b1;
            end else begin
                state <= state + 3'd1;
            end
        end
    end

    // strobes are live only out of reset, not parked, and once S0 is allowed to run;
    // gating with rst keeps every strobe low for the whole reset assertion
    assign active = rst & ~halted & ((state != S0) | (ena & start));

    assign load_ir     = active & dec.load_ir;
    assign rd          = active & dec.rd;
    assign wr          = active & dec.wr;
    assign inc_pc      = active & dec.inc_pc;
    assign load_pc     = active & dec.load_pc;
    assign load_acc    = active & dec.load_acc;
    assign datactl_ena = active & dec.datactl_ena;
    assign halt        = rst & (halted | (active & dec.halt));

endmodule

// File: tb/tb_machine_ctrl.sv
// tb_machine_ctrl: table-driven per-instruction pulse counts, hand sequences for
// reset/ena/halt/step corners, and randomized cycles against a reference model.
// Honours MACHINE_STEP_EN the same way as the design.
module tb_machine_ctrl;

    logic       clk1;
    logic       rst;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       go_in;
    logic       load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt;
    logic [2:0] state;
`ifdef MACHINE_STEP_EN
    logic       step;
    assign go_in = step;
`else
    assign go_in = 1'b1;
`endif

    wire [7:0] act = {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt};

    int checks   = 0;
    int failures = 0;

    int         m_pos  = 0;
    bit         m_park = 1'b0;
    logic [7:0] last_act;

    machine_ctrl dut (
        .clk1        (clk1),
        .rst         (rst),
        .ena         (ena),
        .opcode      (opcode),
        .zero        (zero),
`ifdef MACHINE_STEP_EN
        .step        (step),
`endif
        .load_ir     (load_ir),
        .rd          (rd),
        .wr          (wr),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .load_acc    (load_acc),
        .datactl_ena (datactl_ena),
        .halt        (halt),
        .state       (state)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Expected strobes {load_ir,rd,wr,inc_pc,load_pc,load_acc,datactl_ena,halt}
    // for position pos (0..7) within the current instruction.
    function automatic logic [7:0] model_out(input int pos, input bit park, input logic en,
                                             input logic go, input logic [2:0] opc, input logic z);
        logic [7:0] v;
        bit alu, fetch;
        if (park) return 8'b0000_0001;
        if (pos == 0 && !(en && go)) return 8'h00;
        alu   = (opc inside {3'b010, 3'b011, 3'b100, 3'b101});
        fetch = (pos < 2);
        v[7] = fetch;
        v[6] = fetch || (alu && (pos == 4 || pos == 5));
        v[5] = (opc == 3'b110) && (pos == 5);
        v[4] = fetch || (pos == 3 && opc != 3'b000) || (opc == 3'b001 && z && pos >= 6);
        v[3] = (opc == 3'b111) && (pos == 4 || pos == 5);
        v[2] = alu && (pos == 5);
        v[1] = (opc == 3'b110) && (pos >= 4) && (pos <= 6);
        v[0] = (opc == 3'b000) && (pos == 3);
        return v;
    endfunction

    // Advance the model by one clock using the inputs held during that cycle
    task automatic model_step();
        if (!m_park) begin
            if (!ena)                            m_pos = 0;
            else if (m_pos == 0 && !go_in)       m_pos = 0;
            else if (m_pos == 3 && opcode == 3'b000) m_park = 1'b1;
            else                                 m_pos = (m_pos + 1) % 8;
        end
    endtask

    // Called at posedge+1: drive, compare mid-cycle, cross the edge, update model
    task automatic run_cycle(input logic [2:0] opc, input logic z, input logic en, input string name);
        opcode = opc;
        zero   = z;
        ena    = en;
        #3;
        last_act = act;
        check({name, "_strobes"}, int'(act), int'(model_out(m_pos, m_park, en, go_in, opc, z)));
        check({name, "_state"}, int'(state), m_park ? 3 : m_pos);
        @(posedge clk1);
        #1;
        model_step();
    endtask

    // Assert reset away from any edge, hold across an edge, release with ena=1
    task automatic reset_pulse(input string name);
        rst = 1'b0;
        #1;
        check({name, "_rst_strobes"}, int'(act), 0);
        check({name, "_rst_state"}, int'(state), 0);
        @(posedge clk1);
        #1;
        check({name, "_rst_hold_strobes"}, int'(act), 0);
        check({name, "_rst_hold_state"}, int'(state), 0);
        ena = 1'b1;
        rst = 1'b1;
        #1;
        check({name, "_release_fetch"}, int'(act), 8'b1101_0000);
        check({name, "_release_state"}, int'(state), 0);
        m_pos  = 0;
        m_park = 1'b0;
    endtask

    typedef struct {
        logic [2:0] opc;
        logic       z;
        int         n_inc;
        int         n_rd;
        int         n_wr;
        int         n_lacc;
        int         n_dctl;
        int         n_lpc;
        int         n_ldir;
        int         n_inc_late;
        int         n_rd_late;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3'b010, 1'b0, 3, 4, 0, 1, 0, 0, 2, 0, 2};  // ADD
        vecs[1] = '{3'b011, 1'b1, 3, 4, 0, 1, 0, 0, 2, 0, 2};  // AND
        vecs[2] = '{3'b100, 1'b0, 3, 4, 0, 1, 0, 0, 2, 0, 2};  // XOR
        vecs[3] = '{3'b101, 1'b1, 3, 4, 0, 1, 0, 0, 2, 0, 2};  // LDA
        vecs[4] = '{3'b110, 1'b1, 3, 2, 1, 0, 3, 0, 2, 0, 0};  // STO
        vecs[5] = '{3'b001, 1'b1, 5, 2, 0, 0, 0, 0, 2, 2, 0};  // SKZ taken
        vecs[6] = '{3'b001, 1'b0, 3, 2, 0, 0, 0, 0, 2, 0, 0};  // SKZ not taken
        vecs[7] = '{3'b111, 1'b1, 3, 2, 0, 0, 0, 2, 2, 0, 0};  // JMP

        rst    = 1'b0;
        ena    = 1'b0;
        opcode = 3'b010;
        zero   = 1'b0;
`ifdef MACHINE_STEP_EN
        step   = 1'b1;
`endif
        #1;
        check("por_strobes", int'(act), 0);
        check("por_state", int'(state), 0);
        @(posedge clk1);
        #1;
        reset_pulse("por");

        // Per-instruction pulse counts over one 8-cycle frame
        for (int i = 0; i < 8; i++) begin
            int c_inc, c_rd, c_wr, c_lacc, c_dctl, c_lpc, c_ldir, c_inc_late, c_rd_late;
            c_inc = 0; c_rd = 0; c_wr = 0; c_lacc = 0; c_dctl = 0;
            c_lpc = 0; c_ldir = 0; c_inc_late = 0; c_rd_late = 0;
            for (int k = 0; k < 8; k++) begin
                run_cycle(vecs[i].opc, vecs[i].z, 1'b1, $sformatf("tbl%0d_s%0d", i, k));
                c_ldir += int'(last_act[7]);
                c_rd   += int'(last_act[6]);
                c_wr   += int'(last_act[5]);
                c_inc  += int'(last_act[4]);
                c_lpc  += int'(last_act[3]);
                c_lacc += int'(last_act[2]);
                c_dctl += int'(last_act[1]);
                if (k > 3) c_inc_late += int'(last_act[4]);
                if (k > 1) c_rd_late  += int'(last_act[6]);
            end
            check($sformatf("tbl%0d_inc_pc", i), c_inc, vecs[i].n_inc);
            check($sformatf("tbl%0d_rd", i), c_rd, vecs[i].n_rd);
            check($sformatf("tbl%0d_wr", i), c_wr, vecs[i].n_wr);
            check($sformatf("tbl%0d_load_acc", i), c_lacc, vecs[i].n_lacc);
            check($sformatf("tbl%0d_datactl", i), c_dctl, vecs[i].n_dctl);
            check($sformatf("tbl%0d_load_pc", i), c_lpc, vecs[i].n_lpc);
            check($sformatf("tbl%0d_load_ir", i), c_ldir, vecs[i].n_ldir);
            check($sformatf("tbl%0d_inc_late", i), c_inc_late, vecs[i].n_inc_late);
            check($sformatf("tbl%0d_rd_late", i), c_rd_late, vecs[i].n_rd_late);
            check($sformatf("tbl%0d_frame_end", i), int'(state), 0);
        end

        // Reset in the middle of S5 of ADD
        for (int k = 0; k < 5; k++) run_cycle(3'b010, 1'b0, 1'b1, "add_pre_rst");
        opcode = 3'b010;
        zero   = 1'b0;
        ena    = 1'b1;
        #2;
        check("add_s5_load_acc", int'(load_acc), 1);
        reset_pulse("mid_add");

        // ena drops in S4 of LDA
        for (int k = 0; k < 4; k++) run_cycle(3'b101, 1'b0, 1'b1, "lda_pre");
        run_cycle(3'b101, 1'b0, 1'b0, "lda_s4_ena_low");
        check("ena_abort_state", int'(state), 0);
        check("ena_abort_strobes", int'(act), 0);
        run_cycle(3'b101, 1'b0, 1'b0, "ena_low_hold");
        run_cycle(3'b101, 1'b0, 1'b1, "ena_restart");
        check("ena_restart_s1", int'(state), 1);
        for (int k = 0; k < 7; k++) run_cycle(3'b101, 1'b0, 1'b1, "ena_restart_rest");

        // Randomized frames, ena occasionally dropped
        begin
            logic [2:0] r_opc;
            logic       r_z, r_en;
            r_opc = 3'b010;
            for (int n = 0; n < 300; n++) begin
                if (m_pos == 0) r_opc = 3'($urandom_range(1, 7));
                r_z  = 1'($urandom_range(0, 1));
                r_en = ($urandom_range(0, 19) != 0);
                run_cycle(r_opc, r_z, r_en, "rand");
            end
            while (m_pos != 0) run_cycle(r_opc, 1'b0, 1'b1, "rand_drain");
        end

        // HLT parks at S3; ena toggling is ignored until reset
        for (int k = 0; k < 4; k++) run_cycle(3'b000, 1'b0, 1'b1, "hlt_pre");
        for (int k = 0; k < 20; k++)
            run_cycle(3'b000, 1'($urandom_range(0, 1)), logic'(k % 2), "hlt_parked");
        check("hlt_state_held", int'(state), 3);
        check("hlt_flag_held", int'(halt), 1);
        reset_pulse("hlt_clear");

`ifdef MACHINE_STEP_EN
        // Waits at S0 without step; one pulse runs exactly one frame
        step = 1'b0;
        for (int k = 0; k < 3; k++) run_cycle(3'b010, 1'b0, 1'b1, "step_idle");
        step = 1'b1;
        run_cycle(3'b010, 1'b0, 1'b1, "step_pulse");
        step = 1'b0;
        for (int k = 0; k < 7; k++) run_cycle(3'b010, 1'b0, 1'b1, "step_frame");
        check("step_back_s0", int'(state), 0);
        for (int k = 0; k < 3; k++) run_cycle(3'b010, 1'b0, 1'b1, "step_idle_after");
        check("step_idle_state", int'(state), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
